mchan_trans_arbiter: RTL

Parametrised N-to-1 transaction arbiter for the mchan control unit. It merges transaction descriptors from NB_CTRLS command controllers into the single transfer-unit queue. The block provides:
- round-robin arbitration over any channel count, with no power-of-two padding;
- a configurable burst lock that keeps the grant on one channel for several consecutive transactions;
- a registered output stage, so req_o, data and cid_o are flop outputs.

---
 rtl/mchan_arb_pkg.sv | 33 +++
 rtl/mchan_rr_core.sv | 25 ++
 rtl/mchan_trans_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mchan_arb_pkg.sv
// Shared helpers for the mchan transaction arbiter: channel-id width and
// the round-robin search used by mchan_rr_core.
package mchan_arb_pkg;

  localparam int unsigned MAX_CH = 64;

  function automatic int unsigned cid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Search order ptr, ptr+1, ..., n-1, 0, ..., ptr-1 with a true modulo-n wrap.
  function automatic logic rr_pick(input logic [MAX_CH-1:0] req,
                                   input int unsigned n,
                                   input int unsigned ptr,
                                   output int unsigned idx);
    logic        found;
    int unsigned c;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (i < n && !found) begin
        c = ptr + i;
        if (c >= n) c = c - n;
        if (req[c[5:0]]) begin
          found = 1'b1;
          idx   = c;
        end
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/mchan_rr_core.sv
// Combinational round-robin pick over NB_CTRLS requesters from a start pointer.
module mchan_rr_core
  import mchan_arb_pkg::*;
#(
  parameter int unsigned NB_CTRLS  = 2,
  parameter int unsigned CID_WIDTH = cid_width(NB_CTRLS)
) (
  input  logic [NB_CTRLS-1:0]  req,
  input  logic [CID_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [CID_WIDTH-1:0] idx
);

  logic [MAX_CH-1:0] req_ext;
  int unsigned       pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NB_CTRLS-1:0]  = req;
    pick                   = 0;
    found                  = rr_pick(req_ext, NB_CTRLS, 32'(ptr), pick);
    idx                    = CID_WIDTH'(pick);
  end

endmodule

// File: rtl/mchan_trans_arbiter.sv
// N-to-1 transaction arbiter: round-robin with burst lock and a registered output slot.
// Optional high-priority qualifiers are enabled by defining MCHAN_ARB_PRIO_EN.
module mchan_trans_arbiter
  import mchan_arb_pkg::*;
#(
  parameter int unsigned NB_CTRLS   = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 1,
  parameter int unsigned CID_WIDTH  = cid_width(NB_CTRLS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_CTRLS-1:0]            req_i,
  output logic [NB_CTRLS-1:0]            gnt_o,
  input  logic [NB_CTRLS*DATA_WIDTH-1:0] data_i,
`ifdef MCHAN_ARB_PRIO_EN
  input  logic [NB_CTRLS-1:0]            prio_i,
`endif
  output logic                           req_o,
  input  logic                           gnt_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [CID_WIDTH-1:0]           cid_o
);

  localparam int unsigned BCW = $clog2(BURST_LEN) + 1;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CID_WIDTH-1:0]  out_cid;

  logic [CID_WIDTH-1:0]  ptr;
  logic [CID_WIDTH-1:0]  lock_ch;
  logic                  lock_active;
  logic [BCW-1:0]        burst_cnt;

  logic                  slot_free;
  logic                  lock_hit;
  logic                  use_lock;
  logic [NB_CTRLS-1:0]   eligible;
  logic [NB_CTRLS-1:0]   cand;
  logic                  win_found;
  logic [CID_WIDTH-1:0]  winner;
  logic                  grant;
  logic [BCW-1:0]        burst_base;
  logic                  burst_more;
  logic [CID_WIDTH-1:0]  ptr_next;
`ifdef MCHAN_ARB_PRIO_EN
  logic [NB_CTRLS-1:0]   prio_req;
`endif

  always_comb begin
    slot_free = !out_valid | gnt_i;
    lock_hit  = lock_active & req_i[lock_ch];
`ifdef MCHAN_ARB_PRIO_EN
    prio_req  = req_i & prio_i;
    // A pending priority request breaks a lock held by a non-priority channel.
    use_lock  = lock_hit & (~|prio_req | prio_i[lock_ch]);
    eligible  = (|prio_req) ? prio_req : req_i;
`else
    use_lock  = lock_hit;
    eligible  = req_i;
`endif
    cand = eligible;
    if (use_lock) begin
      cand          = '0;
      cand[lock_ch] = 1'b1;
    end
  end

  mchan_rr_core #(
    .NB_CTRLS  (NB_CTRLS),
    .CID_WIDTH (CID_WIDTH)
  ) u_rr_core (
    .req   (cand),
    .ptr   (ptr),
    .found (win_found),
    .idx   (winner)
  );

  always_comb begin
    grant = slot_free & win_found & !rst_i;
    gnt_o = '0;
    if (grant) gnt_o[winner] = 1'b1;
    // A dropped lock restarts the burst count from zero for the new winner.
    burst_base = use_lock ? burst_cnt : '0;
    burst_more = (BURST_LEN > 1) && (32'(burst_base) + 1 < BURST_LEN);
    ptr_next   = (32'(winner) + 1 == NB_CTRLS) ? '0 : CID_WIDTH'(winner + 1'b1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_cid     <= '0;
      ptr         <= '0;
      lock_ch     <= '0;
      lock_active <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      if (slot_free) begin
        out_valid <= grant;
        if (grant) begin
          out_data <= data_i[winner*DATA_WIDTH +: DATA_WIDTH];
          out_cid  <= winner;
        end
      end
      if (grant) begin
        if (burst_more) begin
          lock_active <= 1'b1;
          lock_ch     <= winner;
          burst_cnt   <= burst_base + 1'b1;
        end else begin
          lock_active <= 1'b0;
          burst_cnt   <= '0;
          ptr         <= ptr_next;
        end
      end else if (slot_free && lock_active && !use_lock) begin
        lock_active <= 1'b0;
        burst_cnt   <= '0;
      end
    end
  end

  assign req_o  = out_valid;
  assign data_o = out_data;
  assign cid_o  = out_cid;

endmodule
